// File: rtl/rtc_bus_pkg.sv
// Shared types and constants for the RTC bus arbiter: FSM states, phase offsets,
// idle pin levels and RTC register addresses.
package rtc_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_GAP  = 3'd2,
    ST_DATA = 3'd3,
    ST_FIN  = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    PH_AD_LO, PH_CS_LO, PH_WR_LO, PH_ABUS, PH_AWR_HI, PH_ACS_HI, PH_AD_HI,
    PH_AREL, PH_DCS_LO, PH_STB_LO, PH_DBUS, PH_STB_HI, PH_DCS_HI, PH_FIN
  } phase_t;

  localparam int          DEF_T_STROBE = 5;
  localparam int          DEF_T_GAP    = 9;
  localparam logic        PIN_IDLE     = 1'b1;
  localparam logic [7:0]  BUS_IDLE     = 8'hFF;

  localparam logic [7:0]  RTC_REG_CTRL = 8'h00;
  localparam logic [7:0]  RTC_REG_SEC  = 8'h01;
  localparam logic [7:0]  RTC_REG_MIN  = 8'h02;
  localparam logic [7:0]  RTC_REG_HOUR = 8'h03;

  // Edge offset of each bus event, counted from the grant edge.
  function automatic int phase_off(input phase_t ph, input int ts, input int tg);
    case (ph)
      PH_AD_LO:  return 1;
      PH_CS_LO:  return 2;
      PH_WR_LO:  return 3;
      PH_ABUS:   return 4;
      PH_AWR_HI: return 4 + ts;
      PH_ACS_HI: return 5 + ts;
      PH_AD_HI:  return 6 + ts;
      PH_AREL:   return 8 + ts;
      PH_DCS_LO: return 8 + ts + tg;
      PH_STB_LO: return 9 + ts + tg;
      PH_DBUS:   return 10 + ts + tg;
      PH_STB_HI: return 10 + 2 * ts + tg;
      PH_DCS_HI: return 11 + 2 * ts + tg;
      PH_FIN:    return 13 + 2 * ts + tg;
      default:   return 0;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: combinational one-hot grant, search starts one past the
// last winner; the pointer moves only when the caller asserts advance.
module rr_arbiter #(
  parameter int NREQ = 3,
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_idx,
  output logic            any
);

  logic [IW-1:0] r_ptr;

  // First pass covers [ptr, NREQ), second pass wraps to [0, ptr).
  always_comb begin
    any       = 1'b0;
    grant_idx = '0;
    grant     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!any && req[i] && (IW'(i) >= r_ptr)) begin
        any       = 1'b1;
        grant_idx = IW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!any && req[i]) begin
        any       = 1'b1;
        grant_idx = IW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      grant[i] = any && (grant_idx == IW'(i));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (advance && any) begin
      r_ptr <= (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + IW'(1);
    end
  end

endmodule

// File: rtl/rtc_bus_arbiter.sv
// Shares the RTC multiplexed address/data bus between NREQ requesters and runs
// one address cycle, a gap and one data cycle per grant.
module rtc_bus_arbiter
  import rtc_bus_pkg::*;
#(
  parameter int NREQ     = 3,
  parameter int T_STROBE = DEF_T_STROBE,
  parameter int T_GAP    = DEF_T_GAP
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_we,
  input  logic [8*NREQ-1:0] req_addr,
  input  logic [8*NREQ-1:0] req_wdata,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [7:0]        rdata,
  output logic              busy,
  output logic              ad,
  output logic              cs,
  output logic              wr,
  output logic              rd,
  output logic [7:0]        bus_out,
  output logic              bus_oe,
  input  logic [7:0]        bus_in,
  output state_t            dbg_state
);

  localparam int IW      = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int FIN_OFF = phase_off(PH_FIN, T_STROBE, T_GAP);
  localparam int CW      = $clog2(FIN_OFF) + 1;

  localparam logic [CW-1:0] C_AD_LO  = CW'(phase_off(PH_AD_LO,  T_STROBE, T_GAP));
  localparam logic [CW-1:0] C_CS_LO  = CW'(phase_off(PH_CS_LO,  T_STROBE, T_GAP));
  localparam logic [CW-1:0] C_WR_LO  = CW'(phase_off(PH_WR_LO,  T_STROBE, T_GAP));
  localparam logic [CW-1:0] C_ABUS   = CW'(phase_off(PH_ABUS,   T_STROBE, T_GAP));
  localparam logic [CW-1:0] C_AWR_HI = CW'(phase_off(PH_AWR_HI, T_STROBE, T_GAP));
  localparam logic [CW-1:0] C_ACS_HI = CW'(phase_off(PH_ACS_HI, T_STROBE, T_GAP));
  localparam logic [CW-1:0] C_AD_HI  = CW'(phase_off(PH_AD_HI,  T_STROBE, T_GAP));
  localparam logic [CW-1:0] C_AREL   = CW'(phase_off(PH_AREL,   T_STROBE, T_GAP));
  localparam logic [CW-1:0] C_DCS_LO = CW'(phase_off(PH_DCS_LO, T_STROBE, T_GAP));
  localparam logic [CW-1:0] C_STB_LO = CW'(phase_off(PH_STB_LO, T_STROBE, T_GAP));
  localparam logic [CW-1:0] C_DBUS   = CW'(phase_off(PH_DBUS,   T_STROBE, T_GAP));
  localparam logic [CW-1:0] C_STB_HI = CW'(phase_off(PH_STB_HI, T_STROBE, T_GAP));
  localparam logic [CW-1:0] C_DCS_HI = CW'(phase_off(PH_DCS_HI, T_STROBE, T_GAP));
  localparam logic [CW-1:0] C_FIN    = CW'(FIN_OFF);

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [NREQ-1:0] r_gnt, r_done;
  logic            r_busy, r_we, r_ad, r_cs, r_wr, r_rd, r_bus_oe;
  logic [7:0]      r_addr, r_wdata, r_rdata, r_bus_out;

  logic [NREQ-1:0] w_grant;
  logic [IW-1:0]   w_idx;
  logic            w_any;
  logic            w_advance;

  assign w_advance = (r_state == ST_IDLE);

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .advance   (w_advance),
    .grant     (w_grant),
    .grant_idx (w_idx),
    .any       (w_any)
  );

  // Handshake: a requester holds req until its one-cycle done; everything it
  // presents is captured at grant, so later input changes are ignored.
  // r_cnt holds the edge number (relative to grant) of the upcoming edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_gnt     <= '0;
      r_done    <= '0;
      r_busy    <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_ad      <= PIN_IDLE;
      r_cs      <= PIN_IDLE;
      r_wr      <= PIN_IDLE;
      r_rd      <= PIN_IDLE;
      r_bus_out <= BUS_IDLE;
      r_bus_oe  <= 1'b0;
    end else begin
      r_done <= '0;
      if (r_state != ST_IDLE) r_cnt <= r_cnt + CW'(1);
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state <= ST_ADDR;
            r_gnt   <= w_grant;
            r_busy  <= 1'b1;
            r_we    <= req_we[w_idx];
            r_addr  <= req_addr[{w_idx, 3'b000} +: 8];
            r_wdata <= req_wdata[{w_idx, 3'b000} +: 8];
            r_cnt   <= CW'(1);
          end
        end
        ST_ADDR: begin
          if (r_cnt == C_AD_LO)  r_ad <= 1'b0;
          if (r_cnt == C_CS_LO)  r_cs <= 1'b0;
          if (r_cnt == C_WR_LO)  r_wr <= 1'b0;
          if (r_cnt == C_ABUS) begin
            r_bus_out <= r_addr;
            r_bus_oe  <= 1'b1;
          end
          if (r_cnt == C_AWR_HI) r_wr <= PIN_IDLE;
          if (r_cnt == C_ACS_HI) r_cs <= PIN_IDLE;
          if (r_cnt == C_AD_HI)  r_ad <= PIN_IDLE;
          if (r_cnt == C_AREL) begin
            r_bus_out <= BUS_IDLE;
            r_bus_oe  <= 1'b0;
            r_state   <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (r_cnt == C_DCS_LO) begin
            r_cs    <= 1'b0;
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (r_cnt == C_STB_LO) begin
            if (r_we) r_wr <= 1'b0;
            else      r_rd <= 1'b0;
          end
          if (r_cnt == C_DBUS && r_we) begin
            r_bus_out <= r_wdata;
            r_bus_oe  <= 1'b1;
          end
          if (r_cnt == C_STB_HI) begin
            r_wr <= PIN_IDLE;
            r_rd <= PIN_IDLE;
            if (!r_we) r_rdata <= bus_in;
          end
          if (r_cnt == C_DCS_HI) begin
            r_cs    <= PIN_IDLE;
            r_state <= ST_FIN;
          end
        end
        ST_FIN: begin
          if (r_cnt == C_FIN) begin
            r_bus_out <= BUS_IDLE;
            r_bus_oe  <= 1'b0;
            r_done    <= r_gnt;
            r_gnt     <= '0;
            r_busy    <= 1'b0;
            r_cnt     <= '0;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign done      = r_done;
  assign rdata     = r_rdata;
  assign busy      = r_busy;
  assign ad        = r_ad;
  assign cs        = r_cs;
  assign wr        = r_wr;
  assign rd        = r_rd;
  assign bus_out   = r_bus_out;
  assign bus_oe    = r_bus_oe;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Directed bench for rtc_bus_arbiter: default-timing instance plus a
// T_STROBE=1/T_GAP=1 instance, every edge of each transaction compared.
module tb_rtc_bus_arbiter;
  import rtc_bus_pkg::*;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic [2:0]  req, req_we, gnt, done;
  logic [23:0] req_addr, req_wdata;
  logic [7:0]  rdata, bus_out, bus_in;
  logic        busy, ad, cs, wr, rd, bus_oe;
  state_t      dbg_state;

  logic [2:0]  f_req, f_req_we, f_gnt, f_done;
  logic [23:0] f_req_addr, f_req_wdata;
  logic [7:0]  f_rdata, f_bus_out, f_bus_in;
  logic        f_busy, f_ad, f_cs, f_wr, f_rd, f_bus_oe;
  state_t      f_dbg_state;

  rtc_bus_arbiter #(.NREQ(3), .T_STROBE(5), .T_GAP(9)) dut (
    .clock(clock), .reset(reset), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .done(done), .rdata(rdata), .busy(busy),
    .ad(ad), .cs(cs), .wr(wr), .rd(rd), .bus_out(bus_out), .bus_oe(bus_oe),
    .bus_in(bus_in), .dbg_state(dbg_state)
  );

  rtc_bus_arbiter #(.NREQ(3), .T_STROBE(1), .T_GAP(1)) dut_fast (
    .clock(clock), .reset(reset), .req(f_req), .req_we(f_req_we), .req_addr(f_req_addr),
    .req_wdata(f_req_wdata), .gnt(f_gnt), .done(f_done), .rdata(f_rdata), .busy(f_busy),
    .ad(f_ad), .cs(f_cs), .wr(f_wr), .rd(f_rd), .bus_out(f_bus_out), .bus_oe(f_bus_oe),
    .bus_in(f_bus_in), .dbg_state(f_dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int         n_assert = 0;
  int         n_fail   = 0;
  logic [7:0] exp_rd[2];

  // Observed vector: {gnt, busy, done, ad, cs, wr, rd, bus_oe, bus_out, rdata}
  function automatic logic [27:0] obs(input bit fast);
    if (fast) return {f_gnt, f_busy, f_done, f_ad, f_cs, f_wr, f_rd, f_bus_oe, f_bus_out, f_rdata};
    return {gnt, busy, done, ad, cs, wr, rd, bus_oe, bus_out, rdata};
  endfunction

  function automatic logic [27:0] idle_vec(input logic [7:0] rdv);
    return {3'b000, 1'b0, 3'b000, 4'b1111, 1'b0, 8'hFF, rdv};
  endfunction

  // Expected pins k edges after the grant edge, from the interval table.
  function automatic logic [27:0] exp_vec(input int k, input int idx, input bit we,
                                          input logic [7:0] a, input logic [7:0] wd,
                                          input logic [7:0] rd0, input logic [7:0] bin,
                                          input int ts, input int tg);
    int fin;
    logic [2:0] oh;
    logic b, e_ad, e_cs, e_wr, e_rd, dlo, abus, dbus, oe;
    logic [7:0] bv, rv;
    fin  = 13 + 2 * ts + tg;
    oh   = 3'b001 << idx;
    b    = (k < fin);
    e_ad = !(k >= 1 && k < 6 + ts);
    e_cs = !((k >= 2 && k < 5 + ts) || (k >= 8 + ts + tg && k < 11 + 2 * ts + tg));
    dlo  = (k >= 9 + ts + tg) && (k < 10 + 2 * ts + tg);
    e_wr = !((k >= 3 && k < 4 + ts) || (we && dlo));
    e_rd = !(!we && dlo);
    abus = (k >= 4) && (k < 8 + ts);
    dbus = we && (k >= 10 + ts + tg) && (k < fin);
    oe   = abus || dbus;
    bv   = abus ? a : (dbus ? wd : 8'hFF);
    rv   = (!we && k >= 10 + 2 * ts + tg) ? bin : rd0;
    return {b ? oh : 3'b000, b, (k == fin) ? oh : 3'b000, e_ad, e_cs, e_wr, e_rd, oe, bv, rv};
  endfunction

  task automatic chk(input string tag, input logic [27:0] o, input logic [27:0] e);
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_gnt(input bit fast, input int budget);
    for (int n = 0; n < budget; n++) begin
      tick();
      if (fast ? (|f_gnt) : (|gnt)) break;
    end
  endtask

  // Called just after the grant edge; compares edges 0..last_k.
  task automatic run_txn(input bit fast, input int idx, input bit we, input logic [7:0] a,
                         input logic [7:0] wd, input logic [7:0] bin, input int last_k,
                         input int drop_at, input string tag);
    int ts, tg;
    ts = fast ? 1 : 5;
    tg = fast ? 1 : 9;
    for (int k = 0; k <= last_k; k++) begin
      if (k > 0) tick();
      chk($sformatf("%s k=%0d", tag, k), obs(fast),
          exp_vec(k, idx, we, a, wd, exp_rd[fast], bin, ts, tg));
      if (k == drop_at) begin
        if (fast) begin
          f_req = f_req & ~(3'b001 << idx);
        end else begin
          req       = req & ~(3'b001 << idx);
          req_addr  = req_addr | (24'hFF << (8 * idx));
          req_wdata = req_wdata | (24'hFF << (8 * idx));
          req_we    = req_we ^ (3'b001 << idx);
        end
      end
    end
    if (!we && last_k >= 10 + 2 * ts + tg) exp_rd[fast] = bin;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b1;
    req = '0; req_we = '0; req_addr = '0; req_wdata = '0; bus_in = 8'h00;
    f_req = '0; f_req_we = '0; f_req_addr = '0; f_req_wdata = '0; f_bus_in = 8'h00;
    exp_rd[0] = 8'h00;
    exp_rd[1] = 8'h00;
    tick();
    tick();
    chk("reset_main", obs(0), idle_vec(8'h00));
    chk("reset_fast", obs(1), idle_vec(8'h00));
    chk("reset_state", 28'(dbg_state), 28'(ST_IDLE));
    reset = 1'b0;
    tick();
    chk("idle_no_req", obs(0), idle_vec(8'h00));

    // Single write from requester 0
    req_we = 3'b001; req_addr[7:0] = RTC_REG_CTRL; req_wdata[7:0] = 8'h18;
    bus_in = 8'hC3; req = 3'b001;
    wait_gnt(0, 4);
    run_txn(0, 0, 1'b1, RTC_REG_CTRL, 8'h18, 8'hC3, 32, -1, "wr0");
    req = 3'b000;
    tick();
    chk("wr0 k=33", obs(0), idle_vec(exp_rd[0]));

    // Single read from requester 2
    req_we = 3'b000; req_addr[23:16] = RTC_REG_MIN; bus_in = 8'h45; req = 3'b100;
    wait_gnt(0, 4);
    run_txn(0, 2, 1'b0, RTC_REG_MIN, 8'h00, 8'h45, 32, -1, "rd2");
    req = 3'b000;
    tick();
    chk("rd2 k=33", obs(0), idle_vec(8'h45));

    // Contention from reset release
    reset = 1'b1;
    req_we = 3'b101; req_addr = {8'h12, 8'h11, 8'h10}; req_wdata = {8'h5A, 8'h00, 8'hA5};
    bus_in = 8'h3C; req = 3'b111;
    tick();
    exp_rd[0] = 8'h00;
    chk("reset2", obs(0), idle_vec(8'h00));
    reset = 1'b0;
    tick();
    run_txn(0, 0, 1'b1, 8'h10, 8'hA5, 8'h3C, 32, -1, "cont0");
    tick();
    run_txn(0, 1, 1'b0, 8'h11, 8'h00, 8'h3C, 32, -1, "cont1");
    tick();
    run_txn(0, 2, 1'b1, 8'h12, 8'h5A, 8'h3C, 32, -1, "cont2");
    tick();
    run_txn(0, 0, 1'b1, 8'h10, 8'hA5, 8'h3C, 32, -1, "cont0b");

    // Requester 1 drops req (and scrambles its inputs) at G+5
    req = 3'b010; req_we = 3'b010; req_wdata[15:8] = 8'h77;
    tick();
    run_txn(0, 1, 1'b1, 8'h11, 8'h77, 8'h3C, 32, 5, "drop1");
    tick();
    chk("drop1 k=33", obs(0), idle_vec(8'h3C));

    // Reset in the middle of a transaction, then pointer restarts at 0
    req_we = 3'b011; req_addr[7:0] = 8'h20; req_wdata[7:0] = 8'h99; req = 3'b001;
    wait_gnt(0, 4);
    run_txn(0, 0, 1'b1, 8'h20, 8'h99, 8'h3C, 14, -1, "abort");
    chk("abort_state", 28'(dbg_state), 28'(ST_GAP));
    reset = 1'b1; req = 3'b011;
    tick();
    exp_rd[0] = 8'h00;
    chk("abort_reset", obs(0), idle_vec(8'h00));
    reset = 1'b0;
    tick();
    run_txn(0, 0, 1'b1, 8'h20, 8'h99, 8'h3C, 32, -1, "regrant");
    req = 3'b000;
    tick();
    chk("regrant k=33", obs(0), idle_vec(8'h00));

    // Short-timing instance: write then read
    f_req_we = 3'b010; f_req_addr[15:8] = RTC_REG_HOUR; f_req_wdata[15:8] = 8'h7E;
    f_bus_in = 8'h99; f_req = 3'b010;
    wait_gnt(1, 4);
    run_txn(1, 1, 1'b1, RTC_REG_HOUR, 8'h7E, 8'h99, 16, -1, "fwr1");
    f_req = 3'b000;
    tick();
    chk("fwr1 k=17", obs(1), idle_vec(8'h00));
    f_req_we = 3'b000; f_req_addr[7:0] = RTC_REG_SEC; f_req = 3'b001;
    wait_gnt(1, 4);
    run_txn(1, 0, 1'b0, RTC_REG_SEC, 8'h00, 8'h99, 16, -1, "frd0");
    f_req = 3'b000;
    tick();
    chk("frd0 k=17", obs(1), idle_vec(8'h99));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/rtc_bus_arbiter.md
# rtc_bus_arbiter

Shares the RTC chip's multiplexed address/data bus between several on-chip requesters: the initialisation sequencer, the user time/date writer and the periodic time reader. It picks one pending request round-robin and runs one complete bus transaction: an address write cycle, a gap, then a data write or read cycle. For reads it returns the captured byte. It is the only block that drives the RTC pins `ad`, `cs`, `wr`, `rd` and the bus byte.

## Interface
Parameters:
- `NREQ`, 3: number of requesters.
- `T_STROBE`, 5: cycles the wr/rd strobe stays low after the bus byte is driven (≥1).
- `T_GAP`, 9: cycles from address release to data-phase `cs` low (≥1).

Ports:
- `clock`  in  1  system clock. One clock domain only.
- `reset`  in  1  synchronous, active-high.
- `req`  in  NREQ  request per requester. Held high until the matching `done`.
- `req_we`  in  NREQ  1 = write transaction, 0 = read transaction.
- `req_addr`  in  8*NREQ  RTC register address. Requester i uses bits [8i+7:8i].
- `req_wdata`  in  8*NREQ  write data, same packing as `req_addr`.
- `gnt`  out  NREQ  one-hot. Shows the requester currently being served.
- `done`  out  NREQ  one-cycle pulse to the served requester at the end of its transaction.
- `rdata`  out  8  byte captured by the last read. Valid from `done` until the next read's capture.
- `busy`  out  1  high while a transaction is in progress.
- `ad`, `cs`, `wr`, `rd`  out  1 each  RTC bus controls, all active-low.
- `bus_out`  out  8  byte driven on the RTC bus.
- `bus_oe`  out  1  pad output enable for `bus_out`.
- `bus_in`  in  8  RTC bus byte as read from the pads.

## Operation
- Reset (takes effect at the next edge, even mid-transaction):
  - `ad`, `cs`, `wr`, `rd` = 1.
  - `bus_out` = 8'hFF, `bus_oe` = 0.
  - `gnt` = 0, `done` = 0, `busy` = 0, `rdata` = 0.
  - Round-robin pointer = 0.
  - No `done` is issued for an aborted transaction.
- States:
  - IDLE: all controls high, bus released. Any `req` bit → latch the winner's `we`, addr and wdata → ADDR.
  - ADDR: address write cycle. Always uses `wr`, never `rd`.
  - GAP: wait only.
  - DATA: data cycle. Uses `wr` with the bus driven for a write. Uses `rd` with `bus_oe` = 0 for a read.
  - FIN: pulse `done`, clear `gnt` and `busy` → IDLE.
- Arbitration:
  - Happens only in IDLE.
  - Round-robin: the search starts at the index after the last winner; after reset it starts at index 0.
  - The pointer advances when a grant is issued.
- Latched values: address, data and direction are latched at grant. Later changes on the request inputs, including `req` dropping, do not affect the transaction, and `done` is still pulsed.
- `rd` and `wr` are never low together. `ad` is high throughout the data phase.

## Timing
All cycle numbers are edges after the grant edge G. Defaults T_STROBE=5, T_GAP=9 give the values in brackets.
- G: `gnt` and `busy` go high.
- Address phase:
  - G+1: `ad`=0.
  - G+2: `cs`=0.
  - G+3: `wr`=0.
  - G+4: `bus_out`=address, `bus_oe`=1.
  - G+4+TS [9]: `wr`=1.
  - G+5+TS [10]: `cs`=1.
  - G+6+TS [11]: `ad`=1.
  - G+8+TS [13]: `bus_out`=FF, `bus_oe`=0.
- Data phase:
  - G+8+TS+TG [22]: `cs`=0.
  - G+9+TS+TG [23]: `wr`=0 for a write, `rd`=0 for a read.
  - G+10+TS+TG [24]: for a write, `bus_out`=wdata and `bus_oe`=1.
  - G+10+2TS+TG [29]: strobe=1. For a read, `rdata` takes `bus_in` sampled at this same edge.
  - G+11+2TS+TG [30]: `cs`=1.
  - G+13+2TS+TG [32]: `bus_out`=FF, `bus_oe`=0, `done` pulses, `gnt`=0, `busy`=0.
- Throughput: the earliest next grant is at the following edge [33]. Transactions are never overlapped.
- Counter: the phase counter must hold 13+2·T_STROBE+T_GAP. Width is $clog2 of that value plus 1.

## Structure
- Package `rtc_bus_pkg` holds:
  - state enum;
  - phase-offset localparams derived from T_STROBE/T_GAP;
  - idle pin values;
  - RTC register address constants (control register 8'h00, etc.).
- Sub-module `rr_arbiter` (NREQ-wide, one-hot grant, pointer update on `advance`) is instantiated once.
- Everything else sits in one FSM plus phase counter, with all outputs registered.

## Test plan
- Single write: requester 0 writes addr 8'h00, data 8'h18. Required response:
  - `bus_out` = 00 during [4,13), then 18 during [24,32).
  - `wr` low during [3,9) and [23,29).
  - `rd` stays high; `done[0]` pulses at edge 32.
- Single read: requester 2 reads addr 8'h02 with `bus_in`=8'h45 around edge 29. Required response:
  - `rd` low during [23,29), `wr` high in the data phase.
  - `bus_oe`=0 during the data phase.
  - `rdata`=45 at `done[2]`.
- Contention: all three `req` held high from reset release. Required response:
  - grants in order 0,1,2,0.
  - each grant is 33 cycles after the previous one.
  - `gnt` is always one-hot or zero.
- Request dropped: `req[1]` falls at G+5. The transaction still completes and `done[1]` pulses at G+32.
- Reset mid-transaction: `reset` asserted at G+15. Required response:
  - next edge: all pins idle, `bus_out`=FF, `busy`=0.
  - no `done` pulse.
  - after release, the next grant goes to index 0.
- Parameter sweep with T_STROBE=1, T_GAP=1: every edge matches the formulas above, and `rd` and `wr` are never low together.
